// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty sequencer: FSM state/phase enums,
// duty width, default parameters and the request clamp helper.
package pwm_ctrl_pkg;

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned GAP_W  = 8;

  localparam int unsigned DefaultMaxDuty  = 10;
  localparam int unsigned DefaultInitDuty = 5;
  localparam int unsigned DefaultStepGap  = 10;

  typedef enum logic [2:0] {
    StCalDn,
    StCalUp,
    StIdle,
    StPulse,
    StGap
  } seq_state_e;

  // Which loop a GAP belongs to, so the end of the gap knows where to return.
  typedef enum logic [1:0] {
    PhCalDn,
    PhCalUp,
    PhRun
  } seq_phase_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] req,
                                                   input logic [DUTY_W-1:0] max_duty);
    return (req > max_duty) ? max_duty : req;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Gap counter: after a start pulse it runs for len cycles and pulses done on the
// last of them. Shared by the calibration and stepping loops.
module step_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned LenW = GAP_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [LenW-1:0] len_i,
  output logic            done_o
);

  logic [LenW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      // A zero length behaves as one cycle so the sequencer can never stall.
      cnt_d = (len_i == '0) ? '0 : len_i - LenW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - LenW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Drives a PWM generator's duty through single-cycle inc/dec pulses separated by
// fixed gaps, after calibrating it down to zero and back up to the initial duty.
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DUTY  = DefaultMaxDuty,
  parameter int unsigned INIT_DUTY = DefaultInitDuty,
  parameter int unsigned STEP_GAP  = DefaultStepGap
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tgt_valid_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  output logic              tgt_ready_o,
  output logic              inc_o,
  output logic              dec_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy_o,
  output logic              cal_done_o,
  output logic              clamped_o
);

  localparam logic [DUTY_W-1:0] MaxDutyL  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] InitDutyL =
      (INIT_DUTY > MAX_DUTY) ? DUTY_W'(MAX_DUTY) : DUTY_W'(INIT_DUTY);
  localparam logic [GAP_W-1:0]  GapLen    = GAP_W'(STEP_GAP);

  seq_state_e        state_q, state_d;
  seq_phase_e        phase_q, phase_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              clamped_q, clamped_d;
  logic              cal_done_q, cal_done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              handshake;
  logic [DUTY_W-1:0] req_duty;
  logic              is_pulse;
  logic              step_up;
  logic              step_dn;
  logic              gap_done;

  assign handshake = tgt_valid_i && ready_q;
  assign req_duty  = clamp_duty(tgt_duty_i, MaxDutyL);
  assign is_pulse  = (state_q == StCalDn) || (state_q == StCalUp) || (state_q == StPulse);
  assign step_up   = (state_q == StCalUp) || ((state_q == StPulse) && (target_q > duty_q));
  assign step_dn   = ((state_q == StCalDn) && (duty_q != '0)) ||
                     ((state_q == StPulse) && (target_q < duty_q));

  step_timer #(
    .LenW(GAP_W)
  ) u_gap_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(is_pulse),
    .len_i  (GapLen),
    .done_o (gap_done)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StCalDn;
      phase_q <= PhCalDn;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic. duty_q already holds the post-pulse value when a gap ends.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      StCalDn, StCalUp, StPulse: state_d = StGap;
      StIdle: begin
        if (handshake && (req_duty != duty_q)) begin
          state_d = StPulse;
        end
      end
      StGap: begin
        if (gap_done) begin
          case (phase_q)
            PhCalDn: begin
              if (duty_q != '0) begin
                state_d = StCalDn;
              end else if (InitDutyL != '0) begin
                state_d = StCalUp;
                phase_d = PhCalUp;
              end else begin
                state_d = StIdle;
                phase_d = PhRun;
              end
            end
            PhCalUp: begin
              if (duty_q != InitDutyL) begin
                state_d = StCalUp;
              end else begin
                state_d = StIdle;
                phase_d = PhRun;
              end
            end
            default: state_d = (duty_q != target_q) ? StPulse : StIdle;
          endcase
        end
      end
      default: begin
        state_d = StCalDn;
        phase_d = PhCalDn;
      end
    endcase
  end

  // Output and datapath next values; every output leaves through a flop.
  always_comb begin
    duty_d    = duty_q;
    target_d  = target_q;
    clamped_d = 1'b0;
    inc_d     = step_up;
    dec_d     = step_dn;
    if (step_up) begin
      duty_d = duty_q + DUTY_W'(1);
    end else if (step_dn) begin
      duty_d = duty_q - DUTY_W'(1);
    end
    if (handshake) begin
      target_d  = req_duty;
      clamped_d = tgt_duty_i > MaxDutyL;
    end
    ready_d    = (state_d == StIdle);
    busy_d     = !ready_d;
    cal_done_d = cal_done_q || ready_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q     <= MaxDutyL;
      target_q   <= InitDutyL;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      clamped_q  <= 1'b0;
      cal_done_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      duty_q     <= duty_d;
      target_q   <= target_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      clamped_q  <= clamped_d;
      cal_done_q <= cal_done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tgt_ready_o = ready_q;
  assign inc_o       = inc_q;
  assign dec_o       = dec_q;
  assign duty_o      = duty_q;
  assign busy_o      = busy_q;
  assign cal_done_o  = cal_done_q;
  assign clamped_o   = clamped_q;

  // Downstream synchroniser/edge detector needs a low cycle between pulses.
  a_pulse_excl : assert property (@(posedge clk_i) disable iff (rst_i) !(inc_q && dec_q));
  a_pulse_gap  : assert property (@(posedge clk_i) disable iff (rst_i)
                                  (inc_q || dec_q) |=> !(inc_q || dec_q));
  a_duty_range : assert property (@(posedge clk_i) disable iff (rst_i) duty_q <= MaxDutyL);

endmodule
